// File: rtl/algo_1r3w_a309_ingress_if.sv
// Client/memory bus bundle for the 1-read/3-write ingress block.
// Latency: none; this interface only carries signals.
// Backpressure: cli_wrdy/cli_rrdy toward clients; ready from the memory.
// Ports: cli_w* are three write ports, cli_r* is one tagged read port,
//        write/wr_adr/din/read/rd_adr drive the memory, rd_* return from it,
//        rsp_* carry tagged read responses, err_unexp is a sticky flag.
// Modports: slave = the ingress block, master = client plus memory side.
interface algo_1r3w_a309_ingress_if #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int BITTAG  = 4
);
  logic [2:0]           cli_wvld;
  logic [2:0]           cli_wrdy;
  logic [3*BITADDR-1:0] cli_wadr;
  logic [3*WIDTH-1:0]   cli_wdin;
  logic                 cli_rvld;
  logic                 cli_rrdy;
  logic [BITADDR-1:0]   cli_radr;
  logic [BITTAG-1:0]    cli_rtag;
  logic                 ready;
  logic [2:0]           write;
  logic [3*BITADDR-1:0] wr_adr;
  logic [3*WIDTH-1:0]   din;
  logic                 read;
  logic [BITADDR-1:0]   rd_adr;
  logic                 rd_vld;
  logic [WIDTH-1:0]     rd_dout;
  logic                 rd_serr;
  logic                 rd_derr;
  logic                 rsp_vld;
  logic [WIDTH-1:0]     rsp_dout;
  logic [BITTAG-1:0]    rsp_tag;
  logic [1:0]           rsp_err;
  logic                 err_unexp;

  modport slave (
    input  cli_wvld, cli_wadr, cli_wdin, cli_rvld, cli_radr, cli_rtag,
    input  ready, rd_vld, rd_dout, rd_serr, rd_derr,
    output cli_wrdy, cli_rrdy, write, wr_adr, din, read, rd_adr,
    output rsp_vld, rsp_dout, rsp_tag, rsp_err, err_unexp
  );

  modport master (
    output cli_wvld, cli_wadr, cli_wdin, cli_rvld, cli_radr, cli_rtag,
    output ready, rd_vld, rd_dout, rd_serr, rd_derr,
    input  cli_wrdy, cli_rrdy, write, wr_adr, din, read, rd_adr,
    input  rsp_vld, rsp_dout, rsp_tag, rsp_err, err_unexp
  );
endinterface

// File: rtl/algo_1r3w_a309_ingress.sv
// Ingress for a 1R3W memory: queues 3 write ports and 1 tagged read port, issues to memory.
// Latency: entry accepted at cycle N issues at N+1 at the earliest; responses pass through same cycle as rd_vld.
// Backpressure: 2-entry queue per port, rdy = not full (from count only); issue stalls while ready=0.
// Ports: clk, rst (sync, active-high), bus (slave modport of algo_1r3w_a309_ingress_if).
module algo_1r3w_a309_ingress #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int BITTAG  = 4,
  parameter int RD_LAT  = 3
) (
  input  logic clk,
  input  logic rst,
  algo_1r3w_a309_ingress_if.slave bus
);

  // Write queues: one 2-entry ring per port, single-bit pointers wrap modulo 2.
  logic [BITADDR-1:0] wAdrMem [3][2];
  logic [WIDTH-1:0]   wDatMem [3][2];
  logic [2:0]         wRdPtr;
  logic [2:0]         wWrPtr;
  logic [1:0]         wCnt [3];

  // Read queue.
  logic [BITADDR-1:0] rAdrMem [2];
  logic [BITTAG-1:0]  rTagMem [2];
  logic               rRdPtr;
  logic               rWrPtr;
  logic [1:0]         rCnt;

  // Tag pipeline, stage RD_LAT-1 lines up with the memory's rd_vld.
  logic [RD_LAT-1:0]  pVld;
  logic [BITTAG-1:0]  pTag [RD_LAT];
  logic               errSticky;

  logic               issueEn;
  logic [2:0]         wRdy;
  logic [2:0]         wPush;
  logic [2:0]         wHeadVld;
  logic [2:0]         wIss;
  logic [BITADDR-1:0] wHeadAdr [3];
  logic [WIDTH-1:0]   wHeadDat [3];
  logic               rRdy;
  logic               rPush;
  logic               rHeadVld;
  logic [BITADDR-1:0] rHeadAdr;
  logic               rIss;
  logic [3*BITADDR-1:0] wrAdrOut;
  logic [3*WIDTH-1:0]   dinOut;
  logic               rspHit;

  assign issueEn = bus.ready && !rst;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      wRdy[p]     = !rst && (wCnt[p] != 2'd2);
      wPush[p]    = bus.cli_wvld[p] && wRdy[p];
      wHeadVld[p] = (wCnt[p] != 2'd0);
      wHeadAdr[p] = wAdrMem[p][wRdPtr[p]];
      wHeadDat[p] = wDatMem[p][wRdPtr[p]];
    end
    rRdy     = !rst && (rCnt != 2'd2);
    rPush    = bus.cli_rvld && rRdy;
    rHeadVld = (rCnt != 2'd0);
    rHeadAdr = rAdrMem[rRdPtr];
  end

  // A write head yields to any lower-indexed valid head on the same address.
  // A lower head that is itself blocked shares the address with an even lower
  // issuing head, so same-address writes always drain in port-index order.
  always_comb begin
    wIss     = '0;
    wrAdrOut = '0;
    dinOut   = '0;
    for (int p = 0; p < 3; p++) begin
      wIss[p] = issueEn && wHeadVld[p];
      for (int i = 0; i < p; i++) begin
        if (wHeadVld[i] && (wHeadAdr[i] == wHeadAdr[p])) wIss[p] = 1'b0;
      end
      if (wIss[p]) begin
        wrAdrOut[p*BITADDR +: BITADDR] = wHeadAdr[p];
        dinOut[p*WIDTH +: WIDTH]       = wHeadDat[p];
      end
    end
  end

  // The read waits whenever it would hit an address being written this cycle.
  always_comb begin
    rIss = issueEn && rHeadVld;
    for (int p = 0; p < 3; p++) begin
      if (wIss[p] && (wHeadAdr[p] == rHeadAdr)) rIss = 1'b0;
    end
  end

  // Queue storage needs no reset; entries are qualified by the counts.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (wPush[p]) begin
        wAdrMem[p][wWrPtr[p]] <= bus.cli_wadr[p*BITADDR +: BITADDR];
        wDatMem[p][wWrPtr[p]] <= bus.cli_wdin[p*WIDTH +: WIDTH];
      end
    end
    if (rPush) begin
      rAdrMem[rWrPtr] <= bus.cli_radr;
      rTagMem[rWrPtr] <= bus.cli_rtag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wRdPtr <= '0;
      wWrPtr <= '0;
      for (int p = 0; p < 3; p++) wCnt[p] <= 2'd0;
      rRdPtr <= 1'b0;
      rWrPtr <= 1'b0;
      rCnt   <= 2'd0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (wPush[p]) wWrPtr[p] <= ~wWrPtr[p];
        if (wIss[p])  wRdPtr[p] <= ~wRdPtr[p];
        wCnt[p] <= wCnt[p] + {1'b0, wPush[p]} - {1'b0, wIss[p]};
      end
      if (rPush) rWrPtr <= ~rWrPtr;
      if (rIss)  rRdPtr <= ~rRdPtr;
      rCnt <= rCnt + {1'b0, rPush} - {1'b0, rIss};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pVld <= '0;
      for (int i = 0; i < RD_LAT; i++) pTag[i] <= '0;
    end else begin
      pVld[0] <= rIss;
      pTag[0] <= rTagMem[rRdPtr];
      for (int i = 1; i < RD_LAT; i++) begin
        pVld[i] <= pVld[i-1];
        pTag[i] <= pTag[i-1];
      end
    end
  end

  // Any disagreement between the expected return slot and rd_vld latches the
  // error; the mismatching beat itself is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      errSticky <= 1'b0;
    end else if (pVld[RD_LAT-1] != bus.rd_vld) begin
      errSticky <= 1'b1;
    end
  end

  assign rspHit = !rst && pVld[RD_LAT-1] && bus.rd_vld;

  assign bus.cli_wrdy  = wRdy;
  assign bus.cli_rrdy  = rRdy;
  assign bus.write     = wIss;
  assign bus.wr_adr    = wrAdrOut;
  assign bus.din       = dinOut;
  assign bus.read      = rIss;
  assign bus.rd_adr    = rIss ? rHeadAdr : '0;
  assign bus.rsp_vld   = rspHit;
  assign bus.rsp_dout  = rspHit ? bus.rd_dout : '0;
  assign bus.rsp_tag   = rspHit ? pTag[RD_LAT-1] : '0;
  assign bus.rsp_err   = rspHit ? {bus.rd_derr, bus.rd_serr} : 2'b00;
  assign bus.err_unexp = errSticky && !rst;

endmodule

// File: tb/tb_algo_1r3w_a309_ingress.sv
// Bench for algo_1r3w_a309_ingress: directed scenarios plus a randomized run against a queue model.
// Latency: inputs driven 1ns after posedge, outputs sampled at negedge.
// Backpressure: model tracks queue occupancy to predict cli_wrdy/cli_rrdy.
module tb_algo_1r3w_a309_ingress;
  localparam int W = 32;
  localparam int A = 13;
  localparam int T = 4;
  localparam int L = 3;

  typedef struct packed { logic [A-1:0] adr; logic [W-1:0] dat; } went_t;
  typedef struct packed { logic [A-1:0] adr; logic [T-1:0] tag; } rent_t;

  logic clk = 1'b0;
  logic rst;
  int   nCmp = 0;
  int   nErr = 0;

  always #5 clk = ~clk;

  algo_1r3w_a309_ingress_if #(.WIDTH(W), .BITADDR(A), .BITTAG(T)) bus ();

  algo_1r3w_a309_ingress #(.WIDTH(W), .BITADDR(A), .BITTAG(T), .RD_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cli_wvld = '0; bus.cli_wadr = '0; bus.cli_wdin = '0;
    bus.cli_rvld = 1'b0; bus.cli_radr = '0; bus.cli_rtag = '0;
    bus.rd_vld = 1'b0; bus.rd_dout = '0; bus.rd_serr = 1'b0; bus.rd_derr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus.ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ready = 1'b1;
    bus.cli_wvld = 3'b111; bus.cli_wadr = {3{A'('h5)}}; bus.cli_wdin = {3{32'h1234_5678}};
    bus.cli_rvld = 1'b1; bus.cli_radr = A'('h5); bus.cli_rtag = 4'h2;
    bus.rd_vld = 1'b0; bus.rd_dout = '0; bus.rd_serr = 1'b0; bus.rd_derr = 1'b0;
    tick();
    @(negedge clk);
    nCmp++; if (bus.cli_wrdy !== 3'b000) begin nErr++; $display("FAIL reset_wrdy: got %b want 000", bus.cli_wrdy); end
    nCmp++; if (bus.cli_rrdy !== 1'b0) begin nErr++; $display("FAIL reset_rrdy: got %b want 0", bus.cli_rrdy); end
    nCmp++; if (bus.write !== 3'b000 || bus.read !== 1'b0) begin nErr++; $display("FAIL reset_strobes: got write=%b read=%b want 000/0", bus.write, bus.read); end
    nCmp++; if (bus.wr_adr !== '0 || bus.din !== '0 || bus.rd_adr !== '0) begin nErr++; $display("FAIL reset_data: got wr_adr=%h din=%h rd_adr=%h want 0", bus.wr_adr, bus.din, bus.rd_adr); end
    nCmp++; if (bus.rsp_vld !== 1'b0 || bus.err_unexp !== 1'b0) begin nErr++; $display("FAIL reset_rsp: got rsp_vld=%b err_unexp=%b want 0/0", bus.rsp_vld, bus.err_unexp); end
    tick();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    nCmp++; if (bus.cli_wrdy !== 3'b111) begin nErr++; $display("FAIL post_reset_wrdy: got %b want 111", bus.cli_wrdy); end
    nCmp++; if (bus.cli_rrdy !== 1'b1) begin nErr++; $display("FAIL post_reset_rrdy: got %b want 1", bus.cli_rrdy); end
    nCmp++; if (bus.write !== 3'b000) begin nErr++; $display("FAIL post_reset_write: got %b want 000", bus.write); end
  endtask

  task automatic test_ready_gating();
    do_reset();
    bus.ready = 1'b0;
    bus.cli_wvld = 3'b001; bus.cli_wadr = {A'(0), A'(0), A'('h11)}; bus.cli_wdin = {32'h0, 32'h0, 32'h1111_0000};
    tick();
    bus.cli_wadr = {A'(0), A'(0), A'('h12)}; bus.cli_wdin = {32'h0, 32'h0, 32'h1212_0000};
    @(negedge clk);
    nCmp++; if (bus.write !== 3'b000) begin nErr++; $display("FAIL gate_write_held: got %b want 000", bus.write); end
    tick();
    bus.cli_wvld = 3'b000;
    @(negedge clk);
    nCmp++; if (bus.cli_wrdy[0] !== 1'b0) begin nErr++; $display("FAIL gate_full_rdy: got %b want 0", bus.cli_wrdy[0]); end
    nCmp++; if (bus.write !== 3'b000) begin nErr++; $display("FAIL gate_full_write: got %b want 000", bus.write); end
    tick();
    bus.ready = 1'b1;
    @(negedge clk);
    nCmp++; if (bus.write !== 3'b001 || bus.wr_adr[A-1:0] !== A'('h11) || bus.din[W-1:0] !== 32'h1111_0000) begin
      nErr++; $display("FAIL gate_first_issue: got write=%b adr=%h din=%h want 001/011/11110000", bus.write, bus.wr_adr[A-1:0], bus.din[W-1:0]); end
    tick();
    @(negedge clk);
    nCmp++; if (bus.write !== 3'b001 || bus.wr_adr[A-1:0] !== A'('h12) || bus.din[W-1:0] !== 32'h1212_0000) begin
      nErr++; $display("FAIL gate_second_issue: got write=%b adr=%h din=%h want 001/012/12120000", bus.write, bus.wr_adr[A-1:0], bus.din[W-1:0]); end
    tick();
    @(negedge clk);
    nCmp++; if (bus.write !== 3'b000 || bus.cli_wrdy !== 3'b111) begin nErr++; $display("FAIL gate_drained: got write=%b wrdy=%b want 000/111", bus.write, bus.cli_wrdy); end
  endtask

  task automatic test_collision();
    do_reset();
    bus.cli_wvld = 3'b101;
    bus.cli_wadr = {A'('h10), A'(0), A'('h10)};
    bus.cli_wdin = {32'hBBBB_0002, 32'h0, 32'hAAAA_0001};
    tick();
    idle_inputs();
    @(negedge clk);
    nCmp++; if (bus.write !== 3'b001 || bus.din[W-1:0] !== 32'hAAAA_0001 || bus.wr_adr[2*A +: A] !== '0) begin
      nErr++; $display("FAIL collide_cycle1: got write=%b din0=%h adr2=%h want 001/aaaa0001/0", bus.write, bus.din[W-1:0], bus.wr_adr[2*A +: A]); end
    tick();
    @(negedge clk);
    nCmp++; if (bus.write !== 3'b100 || bus.din[2*W +: W] !== 32'hBBBB_0002 || bus.wr_adr[2*A +: A] !== A'('h10) || bus.din[W-1:0] !== '0) begin
      nErr++; $display("FAIL collide_cycle2: got write=%b din2=%h adr2=%h din0=%h want 100/bbbb0002/010/0", bus.write, bus.din[2*W +: W], bus.wr_adr[2*A +: A], bus.din[W-1:0]); end
  endtask

  task automatic test_read_hazard();
    do_reset();
    bus.cli_wvld = 3'b001; bus.cli_wadr = {A'(0), A'(0), A'('h20)}; bus.cli_wdin = {32'h0, 32'h0, 32'h2020_2020};
    bus.cli_rvld = 1'b1; bus.cli_radr = A'('h20); bus.cli_rtag = 4'h3;
    tick();
    idle_inputs();
    @(negedge clk);
    nCmp++; if (bus.write !== 3'b001 || bus.read !== 1'b0) begin nErr++; $display("FAIL hazard_hold: got write=%b read=%b want 001/0", bus.write, bus.read); end
    tick();
    @(negedge clk);
    nCmp++; if (bus.read !== 1'b1 || bus.rd_adr !== A'('h20)) begin nErr++; $display("FAIL hazard_release: got read=%b rd_adr=%h want 1/020", bus.read, bus.rd_adr); end
  endtask

  task automatic test_tag_return();
    do_reset();
    bus.cli_rvld = 1'b1; bus.cli_radr = A'('h33); bus.cli_rtag = 4'h5;
    tick();
    idle_inputs();
    @(negedge clk);
    nCmp++; if (bus.read !== 1'b1 || bus.rd_adr !== A'('h33)) begin nErr++; $display("FAIL tag_issue: got read=%b rd_adr=%h want 1/033", bus.read, bus.rd_adr); end
    tick();
    tick();
    @(negedge clk);
    nCmp++; if (bus.rsp_vld !== 1'b0) begin nErr++; $display("FAIL tag_early: got rsp_vld=%b want 0", bus.rsp_vld); end
    tick();
    bus.rd_vld = 1'b1; bus.rd_dout = 32'h0000_CAFE; bus.rd_serr = 1'b1; bus.rd_derr = 1'b0;
    @(negedge clk);
    nCmp++; if (bus.rsp_vld !== 1'b1 || bus.rsp_tag !== 4'h5) begin nErr++; $display("FAIL tag_return: got rsp_vld=%b tag=%h want 1/5", bus.rsp_vld, bus.rsp_tag); end
    nCmp++; if (bus.rsp_dout !== 32'h0000_CAFE || bus.rsp_err !== 2'b01) begin nErr++; $display("FAIL tag_data: got dout=%h err=%b want 0000cafe/01", bus.rsp_dout, bus.rsp_err); end
    tick();
    idle_inputs();
    @(negedge clk);
    nCmp++; if (bus.err_unexp !== 1'b0 || bus.rsp_vld !== 1'b0) begin nErr++; $display("FAIL tag_clean: got err_unexp=%b rsp_vld=%b want 0/0", bus.err_unexp, bus.rsp_vld); end
  endtask

  task automatic test_unexpected();
    do_reset();
    bus.rd_vld = 1'b1; bus.rd_dout = $urandom;
    @(negedge clk);
    nCmp++; if (bus.rsp_vld !== 1'b0) begin nErr++; $display("FAIL unexp_rsp: got rsp_vld=%b want 0", bus.rsp_vld); end
    tick();
    bus.rd_vld = 1'b0;
    @(negedge clk);
    nCmp++; if (bus.err_unexp !== 1'b1) begin nErr++; $display("FAIL unexp_set: got %b want 1", bus.err_unexp); end
    tick();
    tick();
    @(negedge clk);
    nCmp++; if (bus.err_unexp !== 1'b1) begin nErr++; $display("FAIL unexp_hold: got %b want 1", bus.err_unexp); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    nCmp++; if (bus.err_unexp !== 1'b0) begin nErr++; $display("FAIL unexp_in_rst: got %b want 0", bus.err_unexp); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    nCmp++; if (bus.err_unexp !== 1'b0) begin nErr++; $display("FAIL unexp_cleared: got %b want 0", bus.err_unexp); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.cli_wvld = 3'b011; bus.cli_wadr = {A'(0), A'('h50), A'('h50)}; bus.cli_wdin = {32'h0, 32'h5151_5151, 32'h5050_5050};
    bus.cli_rvld = 1'b1; bus.cli_radr = A'('h60); bus.cli_rtag = 4'h9;
    tick();
    idle_inputs();
    @(negedge clk);
    nCmp++; if (bus.write !== 3'b001 || bus.read !== 1'b1) begin nErr++; $display("FAIL midflight_issue: got write=%b read=%b want 001/1", bus.write, bus.read); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    nCmp++; if (bus.cli_wrdy !== 3'b111 || bus.cli_rrdy !== 1'b1 || bus.write !== 3'b000) begin
      nErr++; $display("FAIL midflight_flushed: got wrdy=%b rrdy=%b write=%b want 111/1/000", bus.cli_wrdy, bus.cli_rrdy, bus.write); end
    tick();
    @(negedge clk);
    nCmp++; if (bus.rsp_vld !== 1'b0 || bus.read !== 1'b0 || bus.err_unexp !== 1'b0) begin
      nErr++; $display("FAIL midflight_no_rsp: got rsp_vld=%b read=%b err=%b want 0/0/0", bus.rsp_vld, bus.read, bus.err_unexp); end
  endtask

  // Randomized traffic on a 4-address window so collisions and hazards are frequent.
  // The model keeps plain per-port queues and an ideal memory that answers
  // every read exactly L cycles after issue.
  task automatic test_random();
    went_t              wq [3][$];
    rent_t              rq [$];
    bit                 schV [16];
    logic [T-1:0]       schT [16];
    logic [3*A-1:0]     wa;
    logic [A-1:0]       claimed [$];
    logic [2:0]         eRdy, eWr, pushW;
    logic               eRrdy, eRead, pushR, seen;
    logic [3*A-1:0]     eWa;
    logic [3*W-1:0]     eDin;
    logic [A-1:0]       eRa;
    int                 slot;
    do_reset();
    for (int i = 0; i < 16; i++) begin schV[i] = 1'b0; schT[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      slot = c % 16;
      bus.ready = ($urandom_range(0, 7) != 0);
      bus.cli_wvld = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) wa[p*A +: A] = A'($urandom_range(0, 3));
      bus.cli_wadr = wa;
      bus.cli_wdin = {$urandom, $urandom, $urandom};
      bus.cli_rvld = 1'($urandom_range(0, 1));
      bus.cli_radr = A'($urandom_range(0, 3));
      bus.cli_rtag = T'($urandom_range(0, 15));
      bus.rd_vld  = schV[slot];
      bus.rd_dout = $urandom;
      bus.rd_serr = 1'($urandom_range(0, 1));
      bus.rd_derr = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int p = 0; p < 3; p++) eRdy[p] = (wq[p].size() < 2);
      eRrdy = (rq.size() < 2);
      eWr = '0; eWa = '0; eDin = '0; eRead = 1'b0; eRa = '0;
      claimed.delete();
      // Each address is claimed by the lowest port whose head targets it; others wait.
      for (int p = 0; p < 3; p++) begin
        if (bus.ready && wq[p].size() > 0) begin
          seen = 1'b0;
          foreach (claimed[k]) if (claimed[k] == wq[p][0].adr) seen = 1'b1;
          if (!seen) begin
            eWr[p] = 1'b1;
            eWa[p*A +: A] = wq[p][0].adr;
            eDin[p*W +: W] = wq[p][0].dat;
          end
          claimed.push_back(wq[p][0].adr);
        end
      end
      if (bus.ready && rq.size() > 0) begin
        eRead = 1'b1;
        for (int p = 0; p < 3; p++) if (eWr[p] && eWa[p*A +: A] == rq[0].adr) eRead = 1'b0;
        if (eRead) eRa = rq[0].adr;
      end
      nCmp++; if (bus.cli_wrdy !== eRdy || bus.cli_rrdy !== eRrdy) begin nErr++; $display("FAIL rnd_rdy c=%0d: got %b/%b want %b/%b", c, bus.cli_wrdy, bus.cli_rrdy, eRdy, eRrdy); end
      nCmp++; if (bus.write !== eWr || bus.wr_adr !== eWa || bus.din !== eDin) begin nErr++; $display("FAIL rnd_write c=%0d: got %b %h %h want %b %h %h", c, bus.write, bus.wr_adr, bus.din, eWr, eWa, eDin); end
      nCmp++; if (bus.read !== eRead || bus.rd_adr !== eRa) begin nErr++; $display("FAIL rnd_read c=%0d: got %b %h want %b %h", c, bus.read, bus.rd_adr, eRead, eRa); end
      nCmp++; if (bus.rsp_vld !== schV[slot] || bus.err_unexp !== 1'b0) begin nErr++; $display("FAIL rnd_rsp_vld c=%0d: got %b err=%b want %b err=0", c, bus.rsp_vld, bus.err_unexp, schV[slot]); end
      if (schV[slot]) begin
        nCmp++; if (bus.rsp_tag !== schT[slot] || bus.rsp_dout !== bus.rd_dout || bus.rsp_err !== {bus.rd_derr, bus.rd_serr}) begin
          nErr++; $display("FAIL rnd_rsp_data c=%0d: got tag=%h dout=%h err=%b want tag=%h dout=%h err=%b", c, bus.rsp_tag, bus.rsp_dout, bus.rsp_err, schT[slot], bus.rd_dout, {bus.rd_derr, bus.rd_serr}); end
      end
      pushW = bus.cli_wvld & eRdy;
      pushR = bus.cli_rvld && eRrdy;
      for (int p = 0; p < 3; p++) begin
        if (eWr[p]) void'(wq[p].pop_front());
        if (pushW[p]) wq[p].push_back('{adr: bus.cli_wadr[p*A +: A], dat: bus.cli_wdin[p*W +: W]});
      end
      if (eRead) begin
        schV[(c + L) % 16] = 1'b1;
        schT[(c + L) % 16] = rq[0].tag;
        void'(rq.pop_front());
      end
      if (pushR) rq.push_back('{adr: bus.cli_radr, tag: bus.cli_rtag});
      schV[slot] = 1'b0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    bus.ready = 1'b0;
    idle_inputs();
    test_reset();
    test_ready_gating();
    test_collision();
    test_read_hazard();
    test_tag_return();
    test_unexpected();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
